pe_operand_feeder: RTL
======================

PE_OPERAND_FEEDER -- requirements
Module: pe_operand_feeder

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, operand width (double-precision float).
REQ-002 SHALL have parameter LATENCY, default 16, downstream PE total latency in cycles.
REQ-003 SHALL have port clk  input  1  the single clock; all logic rises on clk.
REQ-004 SHALL have port aresetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cfg_op  input  3  requested PE opcode: 000 add, 010 mul, 011 macc.
REQ-006 SHALL have port cfg_valid  input  1  cfg_op offered.
REQ-007 SHALL have port cfg_ready  output  1  cfg_op accepted this cycle when cfg_valid is also high.
REQ-008 SHALL have ports s_axis_a_tdata/_tvalid/_tlast  input  DWIDTH/1/1  operand A stream.
REQ-009 SHALL have ports s_axis_b_tdata/_tvalid  input  DWIDTH/1  operand B stream.
REQ-010 SHALL have ports s_axis_c_tdata/_tvalid  input  DWIDTH/1  operand C stream (macc addend).
REQ-011 SHALL have ports s_axis_a_tready, s_axis_b_tready, s_axis_c_tready  output  1 each.
REQ-012 SHALL have ports inp1, inp2, inp3  output  DWIDTH each  operands to PE.
REQ-013 SHALL have ports t_valid_inp1, t_valid_inp2, t_last_in  output  1 each  PE beat qualifiers.
REQ-014 SHALL have port op  output  3  opcode driven to PE.
REQ-015 SHALL have ports busy, done, cfg_err  output  1 each  status.
REQ-016 SHALL have port beat_count  output  32  beats issued in current job.

Function
REQ-017 SHALL implement FSM states IDLE, STREAM, DRAIN.
REQ-018 SHALL drive cfg_ready=1 only in IDLE.
REQ-019 On cfg accept with cfg_op in {000,010,011}: SHALL latch op, clear beat_count, go STREAM next cycle.
REQ-020 On cfg accept with any other cfg_op: SHALL pulse cfg_err for one cycle, keep op unchanged, stay IDLE.
REQ-021 In STREAM, issue condition SHALL be A.tvalid & B.tvalid & (C.tvalid | op!=011).
REQ-022 A/B tready SHALL equal the issue condition; C tready SHALL equal the issue condition & (op==011), else 0; no partial consumption.
REQ-023 On issue, inp1<=A, inp2<=B, inp3<=(op==011 ? C : 0), t_valid_inp1=t_valid_inp2<=1, t_last_in<=A.tlast, registered; latency input->PE port exactly 1 cycle.
REQ-024 In any cycle without issue, t_valid_inp1/2 and t_last_in SHALL be 0; data registers hold.
REQ-025 beat_count SHALL increment by 1 per issue, saturating at 2^32-1.
REQ-026 Issue with A.tlast=1 SHALL move STREAM->DRAIN; all tready SHALL be 0 from the following cycle.
REQ-027 DRAIN SHALL last exactly LATENCY+1 cycles (down-counter), then go IDLE, pulsing done for one cycle on the IDLE-entry cycle.
REQ-028 op SHALL remain stable from STREAM entry until IDLE entry; it changes only on a valid cfg accept.
REQ-029 busy SHALL be 1 in STREAM and DRAIN, 0 in IDLE.
REQ-030 Stream inputs while in IDLE or DRAIN SHALL be ignored (tready=0), never lost or consumed.
REQ-031 tlast on a cycle without issue SHALL have no effect.

Reset
REQ-032 aresetn low SHALL immediately force IDLE, op=3'b100 (NoP), inp1/2/3=0, t_valid_inp1/2=0, t_last_in=0, all tready=0, busy=0, done=0, cfg_err=0, beat_count=0, drain counter=0.
REQ-033 Reset asserted mid-STREAM or mid-DRAIN SHALL abort the job with no done pulse; first cfg accepted after release starts cleanly.

Verification
REQ-034 Add job: cfg_op=000; A={1.0,2.0,3.0(tlast)}, B={4.0,5.0,6.0} back-to-back -> three PE beats on consecutive cycles, t_last_in on third, beat_count=3, done exactly LATENCY+2 cycles after last issue cycle.
REQ-035 Macc join: cfg_op=011; A,B valid, C valid delayed 3 cycles -> no tready/issue until C valid, then one beat with inp3=C.
REQ-036 Mul ignores C: cfg_op=010 with C.tvalid=0 -> beats issue, s_axis_c_tready stays 0, inp3=0.
REQ-037 Illegal op: cfg_op=001 -> cfg_err one-cycle pulse, busy=0, op stays 100; then cfg_op=000 accepted normally.
REQ-038 Drain blocking: during DRAIN, new A/B valid and cfg_valid held -> tready=0, cfg_ready=0 until IDLE; cfg accepted on first IDLE cycle.
REQ-039 Async reset: aresetn low mid-job after 2 beats -> same cycle all outputs at reset values, no done; restart job completes correctly.

Source files
------------

// File: rtl/pe_operand_feeder.sv
// rtl/pe_operand_feeder.sv - joins A/B/C operand streams into registered beats for a fixed-latency FP PE
// Issues one beat per cycle while all required operands are valid, then drains the PE pipeline before re-arming.
module pe_operand_feeder #(
    parameter int DWIDTH  = 64,
    parameter int LATENCY = 16
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [2:0]        cfg_op,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DWIDTH-1:0] s_axis_a_tdata,
    input  logic              s_axis_a_tvalid,
    input  logic              s_axis_a_tlast,
    output logic              s_axis_a_tready,
    input  logic [DWIDTH-1:0] s_axis_b_tdata,
    input  logic              s_axis_b_tvalid,
    output logic              s_axis_b_tready,
    input  logic [DWIDTH-1:0] s_axis_c_tdata,
    input  logic              s_axis_c_tvalid,
    output logic              s_axis_c_tready,
    output logic [DWIDTH-1:0] inp1,
    output logic [DWIDTH-1:0] inp2,
    output logic [DWIDTH-1:0] inp3,
    output logic              t_valid_inp1,
    output logic              t_valid_inp2,
    output logic              t_last_in,
    output logic [2:0]        op,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [31:0]       beat_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_MACC = 3'b011;
    localparam logic [2:0] OP_NOP  = 3'b100;

    localparam int CW = $clog2(LATENCY + 2);

    logic [1:0]        r_state;
    logic [2:0]        r_op;
    logic [DWIDTH-1:0] r_inp1;
    logic [DWIDTH-1:0] r_inp2;
    logic [DWIDTH-1:0] r_inp3;
    logic              r_tvalid;
    logic              r_tlast;
    logic              r_done;
    logic              r_cfg_err;
    logic [31:0]       r_beat_count;
    logic [CW-1:0]     r_drain_cnt;

    logic w_is_macc;
    logic w_issue;
    logic w_cfg_accept;
    logic w_cfg_legal;

    assign w_is_macc    = (r_op == OP_MACC);
    assign w_issue      = (r_state == S_STREAM) && s_axis_a_tvalid && s_axis_b_tvalid
                          && (s_axis_c_tvalid || !w_is_macc);
    assign w_cfg_accept = cfg_ready && cfg_valid;
    assign w_cfg_legal  = (cfg_op == OP_ADD) || (cfg_op == OP_MUL) || (cfg_op == OP_MACC);

    // All streams pop together or not at all, so no operand can be partially consumed.
    assign s_axis_a_tready = w_issue;
    assign s_axis_b_tready = w_issue;
    assign s_axis_c_tready = w_issue && w_is_macc;
    assign cfg_ready       = (r_state == S_IDLE);
    assign busy            = (r_state != S_IDLE);

    assign inp1         = r_inp1;
    assign inp2         = r_inp2;
    assign inp3         = r_inp3;
    assign t_valid_inp1 = r_tvalid;
    assign t_valid_inp2 = r_tvalid;
    assign t_last_in    = r_tlast;
    assign op           = r_op;
    assign done         = r_done;
    assign cfg_err      = r_cfg_err;
    assign beat_count   = r_beat_count;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_op         <= OP_NOP;
            r_inp1       <= '0;
            r_inp2       <= '0;
            r_inp3       <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_beat_count <= '0;
            r_drain_cnt  <= '0;
        end else begin
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cfg_accept) begin
                        if (w_cfg_legal) begin
                            r_op         <= cfg_op;
                            r_beat_count <= '0;
                            r_state      <= S_STREAM;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (w_issue) begin
                        r_inp1   <= s_axis_a_tdata;
                        r_inp2   <= s_axis_b_tdata;
                        r_inp3   <= w_is_macc ? s_axis_c_tdata : '0;
                        r_tvalid <= 1'b1;
                        r_tlast  <= s_axis_a_tlast;
                        if (r_beat_count != 32'hFFFF_FFFF) begin
                            r_beat_count <= r_beat_count + 32'd1;
                        end
                        if (s_axis_a_tlast) begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= CW'(LATENCY);
                        end
                    end
                end
                S_DRAIN: begin
                    // Counts LATENCY down to 0 inclusive: LATENCY+1 drain cycles.
                    if (r_drain_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
